// File: rtl/tile_plane_if.sv
// Pixel-side bus of the tile plane: timing strobes in, RAM write ports in,
// and the aligned foreground pixel with its timing strobes out.
interface tile_plane_if #(
    parameter int unsigned MAP_AW = 14
);
    logic              I_de;
    logic              I_hs;
    logic              I_vs;
    logic              I_map_we;
    logic [MAP_AW-1:0] I_map_addr;
    logic [15:0]       I_map_data;
    logic              I_font_we;
    logic [10:0]       I_font_addr;
    logic [7:0]        I_font_data;
    logic              O_de;
    logic              O_hs;
    logic              O_vs;
    logic [23:0]       O_pixel;
    logic              O_opaque;

    modport master (
        output I_de, I_hs, I_vs,
        output I_map_we, I_map_addr, I_map_data,
        output I_font_we, I_font_addr, I_font_data,
        input  O_de, O_hs, O_vs, O_pixel, O_opaque
    );

    modport slave (
        input  I_de, I_hs, I_vs,
        input  I_map_we, I_map_addr, I_map_data,
        input  I_font_we, I_font_addr, I_font_data,
        output O_de, O_hs, O_vs, O_pixel, O_opaque
    );
endinterface

// File: rtl/tile_plane.sv
// Character/tile foreground generator: tile map + 8x8 font lookup feeding the
// plane mixer with an RGB888 pixel and opacity flag, 3-cycle aligned latency.
module tile_plane #(
    parameter int unsigned MAP_COLS = 160,
    parameter int unsigned MAP_ROWS = 90,
    parameter int unsigned MAP_AW   = 14
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    tile_plane_if.slave  bus
);

    localparam int unsigned CNT_W      = 12;
    localparam int unsigned MAP_DEPTH  = MAP_COLS * MAP_ROWS;
    localparam int unsigned FONT_DEPTH = 2048;
    localparam int unsigned X_LIMIT    = MAP_COLS * 8;
    localparam int unsigned Y_LIMIT    = MAP_ROWS * 8;
    localparam int unsigned SYNC_LAT   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [15:0] map_mem  [MAP_DEPTH];
    logic [7:0]  font_mem [FONT_DEPTH];

    // Raster position and edge detection
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic             de_prev_q;
    logic             vs_prev_q;

    // Stage 1 (map entry available) and stage 2 (glyph row available)
    logic [15:0] map_q;
    logic [2:0]  x_d1;
    logic [2:0]  y_d1;
    logic        vis_d1;
    logic [7:0]  font_q;
    logic [7:0]  colour_d2;
    logic [2:0]  x_d2;
    logic        vis_d2;

    logic [SYNC_LAT-1:0] de_sr;
    logic [SYNC_LAT-1:0] hs_sr;
    logic [SYNC_LAT-1:0] vs_sr;
    logic [23:0]         pixel_q;
    logic                opaque_q;

    logic              de_fall_c;
    logic              vs_rise_c;
    logic              in_map_c;
    logic              map_wr_ok_c;
    logic [MAP_AW-1:0] map_rd_addr_c;
    logic [10:0]       font_rd_addr_c;
    logic              glyph_bit_c;
    logic              lit_c;

    function automatic logic [23:0] expand_rgb332(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6],
                c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    // Address generation, bounds checks and bit select
    always_comb begin
        de_fall_c      = de_prev_q & ~bus.I_de;
        vs_rise_c      = bus.I_vs & ~vs_prev_q;
        in_map_c       = (32'(x_q) < X_LIMIT) && (32'(y_q) < Y_LIMIT);
        map_wr_ok_c    = 32'(bus.I_map_addr) < MAP_DEPTH;
        map_rd_addr_c  = '0;
        if (in_map_c) begin
            map_rd_addr_c = MAP_AW'(32'(y_q >> 3) * MAP_COLS + 32'(x_q >> 3));
        end
        font_rd_addr_c = {map_q[7:0], y_d1};
        glyph_bit_c    = font_q[3'd7 - x_d2];
        lit_c          = vis_d2 & glyph_bit_c;
    end

    // Read-first RAMs: a same-cycle read sees the pre-write contents
    always_ff @(posedge I_clk) begin
        if (bus.I_map_we && map_wr_ok_c) begin
            map_mem[bus.I_map_addr] <= bus.I_map_data;
        end
        if (bus.I_font_we) begin
            font_mem[bus.I_font_addr] <= bus.I_font_data;
        end
        map_q  <= map_mem[map_rd_addr_c];
        font_q <= font_mem[font_rd_addr_c];
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            x_d1      <= '0;
            y_d1      <= '0;
            vis_d1    <= 1'b0;
            colour_d2 <= '0;
            x_d2      <= '0;
            vis_d2    <= 1'b0;
            de_sr     <= '0;
            hs_sr     <= '0;
            vs_sr     <= '0;
            pixel_q   <= '0;
            opaque_q  <= 1'b0;
        end else begin
            de_prev_q <= bus.I_de;
            vs_prev_q <= bus.I_vs;

            if (!bus.I_de) begin
                x_q <= '0;
            end else if (x_q != CNT_MAX) begin
                x_q <= x_q + CNT_W'(1);
            end

            // VS rise beats a coincident DE fall
            if (vs_rise_c) begin
                y_q <= '0;
            end else if (de_fall_c && (y_q != CNT_MAX)) begin
                y_q <= y_q + CNT_W'(1);
            end

            x_d1      <= x_q[2:0];
            y_d1      <= y_q[2:0];
            vis_d1    <= bus.I_de & in_map_c;

            colour_d2 <= map_q[15:8];
            x_d2      <= x_d1;
            vis_d2    <= vis_d1;

            pixel_q   <= lit_c ? expand_rgb332(colour_d2) : 24'd0;
            opaque_q  <= lit_c;

            de_sr     <= {de_sr[SYNC_LAT-2:0], bus.I_de};
            hs_sr     <= {hs_sr[SYNC_LAT-2:0], bus.I_hs};
            vs_sr     <= {vs_sr[SYNC_LAT-2:0], bus.I_vs};
        end
    end

    assign bus.O_de     = de_sr[SYNC_LAT-1];
    assign bus.O_hs     = hs_sr[SYNC_LAT-1];
    assign bus.O_vs     = vs_sr[SYNC_LAT-1];
    assign bus.O_pixel  = pixel_q;
    assign bus.O_opaque = opaque_q;

endmodule

// File: tb/tb_tile_plane.sv
// Directed bench for tile_plane: a full-size instance and a 4x2-tile instance
// for the map-boundary cases, checked with immediate assertions.
module tb_tile_plane;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [23:0] pix  [64];
    logic        opq  [64];
    logic        de_h [72];
    logic        hs_h [72];
    logic        vs_early;
    logic        vs_seen;

    tile_plane_if #(.MAP_AW(14)) bus_a ();
    tile_plane_if #(.MAP_AW(4))  bus_b ();

    tile_plane #(.MAP_COLS(160), .MAP_ROWS(90), .MAP_AW(14)) dut_a (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus_a)
    );

    tile_plane #(.MAP_COLS(4), .MAP_ROWS(2), .MAP_AW(4)) dut_b (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] px(input int i);
        return {7'd0, opq[i], pix[i]};
    endfunction

    task automatic wr(input bit sel, input bit mwe, input logic [13:0] maddr,
                      input logic [15:0] mdata, input bit fwe,
                      input logic [10:0] faddr, input logic [7:0] fdata);
        if (sel) begin
            bus_b.I_map_we = mwe;  bus_b.I_map_addr  = 4'(maddr); bus_b.I_map_data  = mdata;
            bus_b.I_font_we = fwe; bus_b.I_font_addr = faddr;     bus_b.I_font_data = fdata;
        end else begin
            bus_a.I_map_we = mwe;  bus_a.I_map_addr  = maddr;     bus_a.I_map_data  = mdata;
            bus_a.I_font_we = fwe; bus_a.I_font_addr = faddr;     bus_a.I_font_data = fdata;
        end
        tick();
        bus_a.I_map_we = 1'b0; bus_a.I_font_we = 1'b0;
        bus_b.I_map_we = 1'b0; bus_b.I_font_we = 1'b0;
    endtask

    task automatic vs_pulse(input bit sel);
        for (int c = 0; c < 6; c++) begin
            if (sel) bus_b.I_vs = (c < 2);
            else     bus_a.I_vs = (c < 2);
            tick();
            if (c == 1) vs_early = sel ? bus_b.O_vs : bus_a.O_vs;
            if (c == 2) vs_seen  = sel ? bus_b.O_vs : bus_a.O_vs;
        end
    endtask

    // Pixel driven in cycle c appears on the outputs after the (c+3)th edge
    task automatic run_line(input bit sel, input int n);
        for (int c = 0; c < n + 4; c++) begin
            if (sel) begin bus_b.I_de = (c < n); bus_b.I_hs = (c == n); end
            else     begin bus_a.I_de = (c < n); bus_a.I_hs = (c == n); end
            tick();
            de_h[c] = sel ? bus_b.O_de : bus_a.O_de;
            hs_h[c] = sel ? bus_b.O_hs : bus_a.O_hs;
            if (c >= 2) begin
                pix[c-2] = sel ? bus_b.O_pixel  : bus_a.O_pixel;
                opq[c-2] = sel ? bus_b.O_opaque : bus_a.O_opaque;
            end
        end
    endtask

    initial begin
        logic [7:0] g;
        bus_a.I_de = 0; bus_a.I_hs = 0; bus_a.I_vs = 0;
        bus_a.I_map_we = 0; bus_a.I_map_addr = '0; bus_a.I_map_data = '0;
        bus_a.I_font_we = 0; bus_a.I_font_addr = '0; bus_a.I_font_data = '0;
        bus_b.I_de = 0; bus_b.I_hs = 0; bus_b.I_vs = 0;
        bus_b.I_map_we = 0; bus_b.I_map_addr = '0; bus_b.I_map_data = '0;
        bus_b.I_font_we = 0; bus_b.I_font_addr = '0; bus_b.I_font_data = '0;
        vs_early = 0; vs_seen = 0;

        // Reset and idle outputs
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_out", {bus_a.O_de, bus_a.O_hs, bus_a.O_vs, bus_a.O_opaque, bus_a.O_pixel}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out", {bus_a.O_de, bus_a.O_hs, bus_a.O_vs, bus_a.O_opaque, bus_a.O_pixel}, 32'd0);
        end

        // Known contents for every tile and glyph row the lines below touch
        wr(0, 1, 14'd1,   16'h0000, 0, 11'd0, 8'h00);
        wr(0, 1, 14'd160, 16'h0000, 0, 11'd0, 8'h00);
        wr(0, 1, 14'd161, 16'h0000, 0, 11'd0, 8'h00);
        for (int r = 0; r < 8; r++) begin
            g = 8'h00; wr(0, 0, 14'd0, 16'h0, 1, {g, 3'(r)}, 8'h00);
            g = 8'h41; wr(0, 0, 14'd0, 16'h0, 1, {g, 3'(r)}, 8'h00);
            g = 8'h42; wr(0, 0, 14'd0, 16'h0, 1, {g, 3'(r)}, 8'h00);
        end
        // Map and font written in the same cycle
        wr(0, 1, 14'd0,   16'hE041, 1, {8'h41, 3'd0}, 8'b1000_0001);
        wr(0, 0, 14'd0,   16'h0000, 1, {8'h41, 3'd3}, 8'hFF);
        wr(0, 1, 14'd160, 16'h1C42, 1, {8'h42, 3'd0}, 8'h80);

        // Scenario 2: first line after VS
        vs_pulse(0);
        chk("vs_delay_early", 32'(vs_early), 32'd0);
        chk("vs_delay",       32'(vs_seen),  32'd1);
        run_line(0, 16);
        chk("de_not_yet",  32'(de_h[1]),  32'd0);
        chk("de_rise",     32'(de_h[2]),  32'd1);
        chk("de_last",     32'(de_h[17]), 32'd1);
        chk("de_fall",     32'(de_h[18]), 32'd0);
        chk("hs_not_yet",  32'(hs_h[17]), 32'd0);
        chk("hs_delay",    32'(hs_h[18]), 32'd1);
        chk("l0_px0", px(0), 32'h01FF0000);
        for (int i = 1; i < 7; i++) chk("l0_px_mid", px(i), 32'd0);
        chk("l0_px7", px(7), 32'h01FF0000);
        chk("l0_px8", px(8), 32'd0);

        // Scenario 3: lines 1..8
        for (int ln = 1; ln <= 8; ln++) begin
            run_line(0, 16);
            if (ln == 3) begin
                for (int i = 0; i < 8; i++) chk("l3_px_red", px(i), 32'h01FF0000);
                chk("l3_px8", px(8), 32'd0);
            end
            if (ln == 8) begin
                chk("l8_px0_green", px(0), 32'h0100FF00);
                chk("l8_px1",       px(1), 32'd0);
            end
        end

        // Scenario 4: VS restarts y at font row 0
        vs_pulse(0);
        run_line(0, 16);
        chk("l0_again_px0", px(0), 32'h01FF0000);
        chk("l0_again_px1", px(1), 32'd0);
        chk("l0_again_px7", px(7), 32'h01FF0000);

        // Scenario 5: 4x2-tile map boundaries
        for (int a = 0; a < 8; a++) wr(1, 1, 14'(a), 16'hE041, 0, 11'd0, 8'h00);
        for (int r = 0; r < 8; r++) wr(1, 0, 14'd0, 16'h0, 1, {8'h41, 3'(r)}, 8'hFF);
        wr(1, 0, 14'd0, 16'h0, 1, {8'h42, 3'd0}, 8'h80);
        wr(1, 1, 14'd8, 16'h1C42, 0, 11'd0, 8'h00);
        vs_pulse(1);
        run_line(1, 40);
        chk("small_px0_unchanged", px(0),  32'h01FF0000);
        chk("small_px31",          px(31), 32'h01FF0000);
        chk("small_px32_oob",      px(32), 32'd0);
        chk("small_px39_oob",      px(39), 32'd0);
        for (int ln = 1; ln <= 16; ln++) begin
            run_line(1, 33);
            if (ln == 15) chk("small_l15_px0", px(0), 32'h01FF0000);
            if (ln == 16) begin
                chk("small_l16_px0",  px(0),  32'd0);
                chk("small_l16_px31", px(31), 32'd0);
            end
        end

        // Scenario 6: async reset mid-line (y=1 here; row 1 lit for visibility)
        wr(0, 0, 14'd0, 16'h0, 1, {8'h41, 3'd1}, 8'hFF);
        for (int c = 0; c < 6; c++) begin
            bus_a.I_de = 1'b1;
            tick();
        end
        chk("pre_reset_px3", {7'd0, bus_a.O_opaque, bus_a.O_pixel}, 32'h01FF0000);
        chk("pre_reset_de",  32'(bus_a.O_de), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_now", {bus_a.O_de, bus_a.O_hs, bus_a.O_vs, bus_a.O_opaque, bus_a.O_pixel}, 32'd0);
        bus_a.I_de = 1'b0;
        repeat (2) tick();
        #3;
        rst_n = 1'b1;
        tick();
        run_line(0, 16);
        chk("post_reset_px0", px(0), 32'h01FF0000);
        chk("post_reset_px1", px(1), 32'd0);
        chk("post_reset_px7", px(7), 32'h01FF0000);
        chk("post_reset_px8", px(8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
